regfile_param: RTL and testbench

// - Parametrised, clocked register file for the single-cycle datapath. Provides 2 async read ports and 1 sync write port.
// - Adds features the first-generation register file lacks: write enable, optional hardwired-zero r0, optional write-to-read bypass.
// - Adds a self-clearing sequencer that zeroes every entry after reset or on request, so no memory-init file is needed.
// - Sits between instruction decode (rs1/rs2/rd) and the ALU/writeback mux.

---
 rtl/regfile_param.sv | 104 ++++++++++
 tb/tb_regfile_param.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// regfile_param: parameterised 2-read / 1-write register file with an
// optional hardwired-zero entry 0, optional same-cycle write bypass, and a
// built-in clear sequencer that zeroes every entry after reset or on request.
module regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  clear_req,
  output logic [DATA_WIDTH-1:0] data1,
  output logic [DATA_WIDTH-1:0] data2,
  output logic                  busy
);

  localparam int                DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH:0]   r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_busy;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_clr_addr;

  assign w_busy     = (r_state == ST_CLEAR);
  // A write to entry 0 is silently dropped when it is hardwired to zero.
  assign w_wr_en    = !w_busy && we && !((ZERO_REG != 0) && (rd == '0));
  assign w_clr_addr = r_cnt[ADDR_WIDTH-1:0];
  assign busy       = w_busy;

  // State and clear-counter register; reset always restarts the clear from 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: walk the counter across every entry, then return to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CNT_LAST) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (clear_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Storage: the clear sequencer owns the array while busy; user writes only in IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_busy)       r_mem[w_clr_addr] <= '0;
      else if (w_wr_en) r_mem[rd]         <= write_data;
    end
  end

  // Read port 1: zero while clearing, zero for hardwired r0, else bypass or array.
  always_comb begin
    data1 = '0;
    if (w_busy)                                  data1 = '0;
    else if ((ZERO_REG != 0) && (rs1 == '0))     data1 = '0;
    else if ((BYPASS != 0) && w_wr_en && (rd == rs1)) data1 = write_data;
    else                                         data1 = r_mem[rs1];
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    data2 = '0;
    if (w_busy)                                  data2 = '0;
    else if ((ZERO_REG != 0) && (rs2 == '0))     data2 = '0;
    else if ((BYPASS != 0) && w_wr_en && (rd == rs2)) data2 = write_data;
    else                                         data2 = r_mem[rs2];
  end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench: three register-file configurations share one stimulus
// stream; a driver pushes model expectations, a monitor pops and compares.
module tb_regfile_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, we = 1'b0, clear_req = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic [31:0] wd = '0;

  logic [31:0] a_d1, a_d2, b_d1, b_d2;
  logic [15:0] c_d1, c_d2;
  logic        a_busy, b_busy, c_busy;

  // A: 32x32, zero reg, bypass
  regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd), .we(we),
    .write_data(wd), .clear_req(clear_req), .data1(a_d1), .data2(a_d2), .busy(a_busy));
  // B: 32x32, plain r0, no bypass
  regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd), .we(we),
    .write_data(wd), .clear_req(clear_req), .data1(b_d1), .data2(b_d2), .busy(b_busy));
  // C: 8x16, zero reg, bypass
  regfile_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1), .BYPASS(1)) u_c (
    .clk(clk), .rst(rst), .rs1(rs1[2:0]), .rs2(rs2[2:0]), .rd(rd[2:0]), .we(we),
    .write_data(wd[15:0]), .clear_req(clear_req), .data1(c_d1), .data2(c_d2), .busy(c_busy));

  logic [2:0][31:0] o_d1, o_d2;
  logic [2:0]       o_busy;
  assign o_d1   = {{16'h0, c_d1}, b_d1, a_d1};
  assign o_d2   = {{16'h0, c_d2}, b_d2, a_d2};
  assign o_busy = {c_busy, b_busy, a_busy};

  // ---------------- reference model ----------------
  int          cfg_depth [3] = '{32, 32, 8};
  logic [31:0] cfg_mask  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
  bit          cfg_z     [3] = '{1'b1, 1'b0, 1'b1};
  bit          cfg_b     [3] = '{1'b1, 1'b0, 1'b1};

  logic [31:0] m_mem  [3][32];
  int          m_busy [3];
  bit          m_init = 1'b0;

  function automatic logic [4:0] m_addr(int n, logic [4:0] a);
    logic [4:0] msk;
    msk = 5'(cfg_depth[n] - 1);
    return a & msk;
  endfunction

  // Zero while clearing; r0 hardwired; bypass of a live write; else storage.
  function automatic logic [31:0] m_read(int n, logic [4:0] a);
    logic [4:0] aa, rr;
    bit         wr_ok;
    aa = m_addr(n, a);
    rr = m_addr(n, rd);
    wr_ok = we && !(cfg_z[n] && rr == 5'd0);
    if (m_busy[n] > 0)                 return 32'h0;
    if (cfg_z[n] && aa == 5'd0)        return 32'h0;
    if (cfg_b[n] && wr_ok && rr == aa) return wd & cfg_mask[n];
    return m_mem[n][aa];
  endfunction

  // Effect of the upcoming clock edge. A clear zeroes the whole array at
  // once: while busy nothing is readable or writable, so this is equivalent.
  task automatic m_edge();
    for (int n = 0; n < 3; n++) begin
      logic [4:0] rr;
      rr = m_addr(n, rd);
      if (rst) begin
        for (int i = 0; i < 32; i++) m_mem[n][i] = 32'h0;
        m_busy[n] = cfg_depth[n];
      end else if (m_busy[n] > 0) begin
        m_busy[n]--;
      end else begin
        if (we && !(cfg_z[n] && rr == 5'd0)) m_mem[n][rr] = wd & cfg_mask[n];
        if (clear_req) begin
          for (int i = 0; i < 32; i++) m_mem[n][i] = 32'h0;
          m_busy[n] = cfg_depth[n];
        end
      end
    end
    if (rst) m_init = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int               ph;
    logic [2:0][31:0] d1;
    logic [2:0][31:0] d2;
    logic [2:0]       busy;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic cycle(input logic r, input logic w, input logic [4:0] a_rd,
                       input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2,
                       input logic clr, input int ph);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; we = w; rd = a_rd; wd = d; rs1 = a1; rs2 = a2; clear_req = clr;
    if (m_init) begin
      e.ph = ph;
      for (int n = 0; n < 3; n++) begin
        e.d1[n]   = m_read(n, a1);
        e.d2[n]   = m_read(n, a2);
        e.busy[n] = (m_busy[n] > 0);
      end
      sb.push_back(e);
    end
    m_edge();
  endtask

  // Monitor: outputs are combinational, so a result is presented every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int n = 0; n < 3; n++) begin
          checks++;
          if (o_busy[n] !== e.busy[n]) begin
            errors++;
            $display("FAIL ph%0d dut%0d busy got %b exp %b", e.ph, n, o_busy[n], e.busy[n]);
          end
          checks++;
          if (o_d1[n] !== e.d1[n]) begin
            errors++;
            $display("FAIL ph%0d dut%0d data1 got %h exp %h", e.ph, n, o_d1[n], e.d1[n]);
          end
          checks++;
          if (o_d2[n] !== e.d2[n]) begin
            errors++;
            $display("FAIL ph%0d dut%0d data2 got %h exp %h", e.ph, n, o_d2[n], e.d2[n]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // ph0: reset and full clear
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) cycle(0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0);
    // ph1: every entry reads zero after the clear
    for (int i = 0; i < 32; i++) cycle(0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 1);
    // ph2: bypass vs. next-cycle visibility
    cycle(0, 1, 5, 32'hDEAD_BEEF, 5, 5, 0, 2);
    cycle(0, 0, 0, 0, 5, 5, 0, 2);
    // ph3: writes to r0
    cycle(0, 1, 0, 32'h0000_1234, 0, 0, 0, 3);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 3);
    // ph4: clear request wipes contents and blocks writes
    cycle(0, 1, 7, 32'hA5A5_A5A5, 7, 8, 0, 4);
    cycle(0, 0, 0, 0, 7, 8, 1, 4);
    for (int i = 0; i < 32; i++) cycle(0, (i == 3), 8, 32'h1111_2222, 7, 8, (i == 5), 4);
    cycle(0, 0, 0, 0, 7, 8, 0, 4);
    // ph5: reset mid-clear restarts the full sequence
    cycle(1, 0, 0, 0, 3, 3, 0, 5);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 3, 3, 0, 5);
    cycle(1, 1, 3, 32'h99, 3, 3, 1, 5);
    for (int i = 0; i < 32; i++) cycle(0, 0, 0, 0, 3, 3, 0, 5);
    cycle(0, 1, 3, 32'h55, 3, 4, 0, 5);
    cycle(0, 0, 0, 0, 3, 3, 0, 5);
    // ph6: random traffic
    for (int i = 0; i < 1000; i++) begin
      logic [4:0]  r_rd, r_a1, r_a2;
      r_rd = 5'($urandom);
      r_a1 = ($urandom_range(0, 3) == 0) ? r_rd : 5'($urandom);
      r_a2 = ($urandom_range(0, 3) == 0) ? r_rd : 5'($urandom);
      cycle(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)), r_rd, $urandom,
            r_a1, r_a2, ($urandom_range(0, 99) == 0), 6);
    end
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain scoreboard left %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
